// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word type, fetch FSM states and reset PC for the pipelined core
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    localparam word_t PC_RESET = 32'h00000000;
    typedef enum logic {FETCH, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline latch; clr inserts a NOP bubble and wins over en
module if_id_reg
    import cpu_types_pkg::*;
#(
    parameter word_t NOP_INSTR = 32'h00000000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  en,
    input  logic  clr,
    input  word_t instr_in,
    input  word_t pc_in,
    input  word_t npc_in,
    input  logic  valid_in,
    output word_t instr,
    output word_t pc,
    output word_t npc,
    output logic  valid
);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end else if (en) begin
            instr <= instr_in;
            pc    <= pc_in;
            npc   <= npc_in;
            valid <= valid_in;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, buffered redirect and fetch/halt FSM feeding the IF/ID latch
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT   = PC_RESET,
    parameter word_t NOP_INSTR = 32'h00000000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  flush,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t instr,
    output word_t pc_out,
    output word_t npc_out,
    output logic  valid_out,
    output logic  halted
);
    fetch_state_t state, next_state;
    word_t pc, pc_next, redir_pc, redir_pc_next;
    logic redir_pending, redir_pending_next;
    logic ld, clr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= FETCH;
            pc            <= PC_INIT;
            redir_pending <= 1'b0;
            redir_pc      <= '0;
        end else begin
            state         <= next_state;
            pc            <= pc_next;
            redir_pending <= redir_pending_next;
            redir_pc      <= redir_pc_next;
        end
    end

    always_comb begin
        next_state         = state;
        pc_next            = pc;
        redir_pending_next = redir_pending;
        redir_pc_next      = redir_pc;
        imemREN            = 1'b0;
        halted             = 1'b0;
        ld                 = 1'b0;
        clr                = 1'b0;
        if (state == FETCH) begin
            imemREN = 1'b1;
            // a HALT on the wrong path (redirect/flush same cycle) is ignored
            if (halt && valid_out && !redirect && !flush) begin
                next_state = HALTED;
            end else begin
                if (ihit) begin
                    if (redirect) begin
                        pc_next            = redirect_pc;
                        redir_pending_next = 1'b0;
                    end else if (redir_pending) begin
                        pc_next            = redir_pc;
                        redir_pending_next = 1'b0;
                    end else if (!stall) begin
                        pc_next = pc + 32'd4;
                    end
                end else if (redirect) begin
                    // request is outstanding: keep imemaddr stable, apply on ihit
                    redir_pending_next = 1'b1;
                    redir_pc_next      = redirect_pc;
                end
                ld  = ihit && !redir_pending && !redirect && !flush && !stall;
                clr = redirect || flush || (!stall && !ld);
            end
        end else begin
            halted = 1'b1;
        end
    end

    assign imemaddr = pc;

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .CLK      (CLK),
        .nRST     (nRST),
        .en       (ld),
        .clr      (clr),
        .instr_in (imemload),
        .pc_in    (pc),
        .npc_in   (pc + 32'd4),
        .valid_in (1'b1),
        .instr    (instr),
        .pc       (pc_out),
        .npc      (npc_out),
        .valid    (valid_out)
    );
endmodule
